// File: rtl/aes_key_expansion.sv
// aes_key_expansion: registered AES-128 key schedule producing round-key words w0..w43 one cycle after key is sampled
module aes_key_expansion (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key,
  output logic [31:0]  w0,
  output logic [31:0]  w1,
  output logic [31:0]  w2,
  output logic [31:0]  w3,
  output logic [31:0]  w4,
  output logic [31:0]  w5,
  output logic [31:0]  w6,
  output logic [31:0]  w7,
  output logic [31:0]  w8,
  output logic [31:0]  w9,
  output logic [31:0]  w10,
  output logic [31:0]  w11,
  output logic [31:0]  w12,
  output logic [31:0]  w13,
  output logic [31:0]  w14,
  output logic [31:0]  w15,
  output logic [31:0]  w16,
  output logic [31:0]  w17,
  output logic [31:0]  w18,
  output logic [31:0]  w19,
  output logic [31:0]  w20,
  output logic [31:0]  w21,
  output logic [31:0]  w22,
  output logic [31:0]  w23,
  output logic [31:0]  w24,
  output logic [31:0]  w25,
  output logic [31:0]  w26,
  output logic [31:0]  w27,
  output logic [31:0]  w28,
  output logic [31:0]  w29,
  output logic [31:0]  w30,
  output logic [31:0]  w31,
  output logic [31:0]  w32,
  output logic [31:0]  w33,
  output logic [31:0]  w34,
  output logic [31:0]  w35,
  output logic [31:0]  w36,
  output logic [31:0]  w37,
  output logic [31:0]  w38,
  output logic [31:0]  w39,
  output logic [31:0]  w40,
  output logic [31:0]  w41,
  output logic [31:0]  w42,
  output logic [31:0]  w43
);

  // Forward S-box, byte x lives at bit offset 8*(255-x), i.e. 8*~x.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Round constants for rounds 1..10, round 1 in the top byte.
  localparam logic [79:0] RCON = 80'h01_02_04_08_10_20_40_80_1b_36;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  logic [31:0] w_d [44];
  logic [31:0] w_q [44];
  logic [31:0] t;

  // Full key schedule straight from the key input so outputs land one edge after sampling.
  always_comb begin
    t = '0;
    w_d[0] = key[127:96];
    w_d[1] = key[95:64];
    w_d[2] = key[63:32];
    w_d[3] = key[31:0];
    for (int r = 1; r <= 10; r++) begin
      t = sub_word({w_d[4*r-1][23:0], w_d[4*r-1][31:24]}) ^ {RCON[8*(10-r) +: 8], 24'h0};
      w_d[4*r]   = w_d[4*r-4] ^ t;
      w_d[4*r+1] = w_d[4*r-3] ^ w_d[4*r];
      w_d[4*r+2] = w_d[4*r-2] ^ w_d[4*r+1];
      w_d[4*r+3] = w_d[4*r-1] ^ w_d[4*r+2];
    end
  end

  // All 44 words load together every edge; reset clears them without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_q <= '{default: '0};
    else w_q <= w_d;
  end

  assign w0  = w_q[0];
  assign w1  = w_q[1];
  assign w2  = w_q[2];
  assign w3  = w_q[3];
  assign w4  = w_q[4];
  assign w5  = w_q[5];
  assign w6  = w_q[6];
  assign w7  = w_q[7];
  assign w8  = w_q[8];
  assign w9  = w_q[9];
  assign w10 = w_q[10];
  assign w11 = w_q[11];
  assign w12 = w_q[12];
  assign w13 = w_q[13];
  assign w14 = w_q[14];
  assign w15 = w_q[15];
  assign w16 = w_q[16];
  assign w17 = w_q[17];
  assign w18 = w_q[18];
  assign w19 = w_q[19];
  assign w20 = w_q[20];
  assign w21 = w_q[21];
  assign w22 = w_q[22];
  assign w23 = w_q[23];
  assign w24 = w_q[24];
  assign w25 = w_q[25];
  assign w26 = w_q[26];
  assign w27 = w_q[27];
  assign w28 = w_q[28];
  assign w29 = w_q[29];
  assign w30 = w_q[30];
  assign w31 = w_q[31];
  assign w32 = w_q[32];
  assign w33 = w_q[33];
  assign w34 = w_q[34];
  assign w35 = w_q[35];
  assign w36 = w_q[36];
  assign w37 = w_q[37];
  assign w38 = w_q[38];
  assign w39 = w_q[39];
  assign w40 = w_q[40];
  assign w41 = w_q[41];
  assign w42 = w_q[42];
  assign w43 = w_q[43];

endmodule

// File: tb/tb_aes_key_expansion.sv
// tb_aes_key_expansion: directed known-answer checks of the AES-128 key schedule
module tb_aes_key_expansion;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [127:0] key = '0;
  logic [31:0]  w [44];
  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] K2  = 128'h0f1571c9_47d9e859_0cb7add6_af7f6798;
  localparam logic [127:0] K2A = 128'hdc9037b0_9b49dfe9_97fe723f_388115a7;
  localparam logic [127:0] K2Z = 128'hb48ef352_ba98134e_7f4d5920_86261876;
  localparam logic [127:0] K3  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] K3A = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] K3Z = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
  localparam logic [127:0] K0  = 128'h0;
  localparam logic [127:0] K0A = 128'h62636363_62636363_62636363_62636363;
  localparam logic [127:0] K0Z = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;

  always #5 clk = ~clk;

  aes_key_expansion dut (
    .clk(clk), .rst_n(rst_n), .key(key),
    .w0(w[0]),   .w1(w[1]),   .w2(w[2]),   .w3(w[3]),   .w4(w[4]),   .w5(w[5]),
    .w6(w[6]),   .w7(w[7]),   .w8(w[8]),   .w9(w[9]),   .w10(w[10]), .w11(w[11]),
    .w12(w[12]), .w13(w[13]), .w14(w[14]), .w15(w[15]), .w16(w[16]), .w17(w[17]),
    .w18(w[18]), .w19(w[19]), .w20(w[20]), .w21(w[21]), .w22(w[22]), .w23(w[23]),
    .w24(w[24]), .w25(w[25]), .w26(w[26]), .w27(w[27]), .w28(w[28]), .w29(w[29]),
    .w30(w[30]), .w31(w[31]), .w32(w[32]), .w33(w[33]), .w34(w[34]), .w35(w[35]),
    .w36(w[36]), .w37(w[37]), .w38(w[38]), .w39(w[39]), .w40(w[40]), .w41(w[41]),
    .w42(w[42]), .w43(w[43])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_key(input string tag, input logic [127:0] k, input logic [127:0] r1, input logic [127:0] r10);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("%s w%0d", tag, j), w[j], k[127-32*j -: 32]);
      check($sformatf("%s w%0d", tag, j+4), w[j+4], r1[127-32*j -: 32]);
      check($sformatf("%s w%0d", tag, j+40), w[j+40], r10[127-32*j -: 32]);
    end
  endtask

  task automatic check_zero(input string tag);
    for (int j = 0; j < 44; j++) check($sformatf("%s w%0d", tag, j), w[j], 32'h0);
  endtask

  initial begin
    key = K2;
    #1 rst_n = 1'b0;
    #1 check_zero("reset");
    #1 rst_n = 1'b1;
    #1 check("pre-edge", w[0], 32'h0);
    @(negedge clk);
    check_key("textbook", K2, K2A, K2Z);
    key = K3;
    @(negedge clk);
    check_key("fips", K3, K3A, K3Z);
    key = K0;
    @(negedge clk);
    check_key("zero", K0, K0A, K0Z);
    key = K2;
    @(negedge clk);
    check_key("b2b textbook", K2, K2A, K2Z);
    key = K3;
    @(negedge clk);
    check_key("b2b fips", K3, K3A, K3Z);
    @(negedge clk);
    check_key("hold fips", K3, K3A, K3Z);
    #1 rst_n = 1'b0;
    #1 check_zero("mid reset");
    key = K2;
    #1 rst_n = 1'b1;
    #1 check("released pre-edge", w[40], 32'h0);
    @(negedge clk);
    check_key("after reset", K2, K2A, K2Z);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/aes_key_expansion.md
Name: aes_key_expansion

Overview:
- Registered AES-128 key schedule. Expands a 128-bit cipher key into the 44 round-key words w0..w43 (FIPS-197, Nk=4, Nr=10).
- Sits beside the AES round datapath and feeds the eleven 128-bit round keys {w(4r), w(4r+1), w(4r+2), w(4r+3)}, r = 0..10.
- Expansion is fully combinational from the key register. Results are captured in output registers, so every output is valid one clock after the key is sampled.

Parameters:
- None. AES-128 only; widths are fixed.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- key  input  128  cipher key. Byte 0 is key[127:120]; w0 = key[127:96], w1 = key[95:64], w2 = key[63:32], w3 = key[31:0].
- w0..w43  output  32 each  expanded key words, registered. w0..w3 are the key words; w40..w43 are the round-10 key.

Interface (already decided):
- One clock.
- Reset is asynchronous and active-low.

Behaviour:
- Reset: while rst_n = 0, all w0..w43 are 0 immediately, independent of clk. First update occurs on the first rising clk edge after rst_n deasserts.
- Every rising clk edge with rst_n = 1 samples key and loads all 44 words. Latency is exactly 1 cycle. Throughput is one key per cycle. There is no handshake and no enable.
- A key change updates every w on the same edge; no word lags another.
- Expansion for i = 4..43:
  - temp = w(i-1).
  - If i mod 4 = 0: temp = SubWord(RotWord(temp)) XOR {Rcon(i/4), 24'h0}.
  - w(i) = w(i-4) XOR temp.
- RotWord({a,b,c,d}) = {b,c,d,a}, with byte a being bits [31:24].
- SubWord applies the standard AES forward S-box to each byte independently. The S-box is a 256-entry constant table (function or ROM), implemented combinationally. The design needs 40 S-box instances (4 per round, rounds 1..10).
- Rcon(1..10) = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36 (hex, placed in the MSB byte).
- All arithmetic is bitwise XOR. There are no carries and no width growth.
- Outputs are register outputs only; there is no combinational path from key to any w.
- Reset mid-operation: outputs clear asynchronously. On release, the next edge reloads from the current key.
- No X propagation: a fully defined key yields fully defined outputs on the next edge.

Test Plan:
1. Reset check: assert rst_n = 0 with any key -> all w0..w43 = 0 without a clock edge. Deassert, apply one edge -> outputs reflect key.
2. Textbook key 0f1571c9_47d9e859_0cb7add6_af7f6798, one edge ->
   - w0..w3 equal the key words.
   - w4 = dc9037b0, w5 = 9b49dfe9, w6 = 97fe723f, w7 = 388115a7.
   - w40..w43 = b48ef352, ba98134e, 7f4d5920, 86261876.
3. FIPS-197 key 2b7e1516_28aed2a6_abf71588_09cf4f3c ->
   - w4 = a0fafe17.
   - w40..w43 = d014f9a8, c9ee2589, e13f0cc8, b6630ca6.
4. All-zero key ->
   - w4..w7 = 62636363 each.
   - w40..w43 = b4ef5bcb, 3e92e211, 23e951cf, 6f8f188e.
5. Latency and back-to-back keys: change key on consecutive edges (scenario 2 key, then scenario 3 key) -> each edge presents the expansion of the key sampled at that edge, with no mixing of words between keys.
6. Async reset mid-stream: pulse rst_n low between edges while a valid expansion is held -> outputs drop to 0 immediately. After release they match the current key one edge later.
